// File: rtl/strip_trigger_ser_pkg.sv
// Shared widths, frame geometry helpers and FSM state type for the strip trigger serialiser.
package strip_trig_pkg;

    localparam int unsigned PHI_W_DEF  = 5;
    localparam int unsigned BAND_W_DEF = 8;
    localparam int unsigned BCID_W_DEF = 12;

    function automatic int unsigned frame_width(input int unsigned phi_w,
                                                input int unsigned band_w,
                                                input int unsigned bcid_w);
        return phi_w + band_w + bcid_w;
    endfunction

    function automatic int unsigned beat_count(input int unsigned w, input int unsigned n_lanes);
        return (w + n_lanes - 1) / n_lanes;
    endfunction

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

endpackage

// File: rtl/strip_trigger_ser_if.sv
// Trigger request channel: valid/ready handshake carrying phi, band and BCID fields.
interface strip_trigger_ser_if #(
    parameter int unsigned PHI_W  = strip_trig_pkg::PHI_W_DEF,
    parameter int unsigned BAND_W = strip_trig_pkg::BAND_W_DEF,
    parameter int unsigned BCID_W = strip_trig_pkg::BCID_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [PHI_W-1:0]  in_phi;
    logic [BAND_W-1:0] in_band;
    logic [BCID_W-1:0] in_bcid;

    modport master (output in_valid, in_phi, in_band, in_bcid, input in_ready);
    modport slave  (input in_valid, in_phi, in_band, in_bcid, output in_ready);
endinterface

// File: rtl/strip_trigger_ser_fifo.sv
// Synchronous request FIFO; ready is a registered not-full flag held low during reset.
module trig_fifo #(
    parameter int unsigned W     = 25,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk_slow,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         ready,
    output logic         empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q;
    logic          push_ok, pop_ok;

    // ready_q already means "not full", so a pop in the same cycle never admits a push
    assign push_ok = push & ready_q;
    assign pop_ok  = pop & (count_q != '0);
    assign count_d = count_q + CW'(push_ok) - CW'(pop_ok);

    assign rd_data = mem[rd_ptr_q];
    assign ready   = ready_q;
    assign empty   = (count_q == '0);

    always_ff @(posedge clk_slow or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ready_q <= (count_d != CW'(DEPTH));
        end
    end

    always_ff @(posedge clk_slow) begin
        if (push_ok) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/strip_trigger_ser.sv
// Strip trigger serialiser: queued requests emitted as MSB-first multi-lane bursts with idle gaps.
module strip_trigger_ser
    import strip_trig_pkg::*;
#(
    parameter int unsigned PHI_W      = PHI_W_DEF,
    parameter int unsigned BAND_W     = BAND_W_DEF,
    parameter int unsigned BCID_W     = BCID_W_DEF,
    parameter int unsigned N_LANES    = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic               clk_slow,
    input  logic               reset,
    strip_trigger_ser_if.slave req,
    output logic               trig_en,
    output logic [N_LANES-1:0] trig_d,
    output logic               idle,
    output logic [15:0]        frame_cnt
);
    localparam int unsigned W     = frame_width(PHI_W, BAND_W, BCID_W);
    localparam int unsigned BEATS = beat_count(W, N_LANES);
    localparam int unsigned L     = BEATS * N_LANES;
    localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned GCW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic [W-1:0]       wr_word, rd_word;
    logic               fifo_ready, fifo_empty, pop;
    state_e             state_q, state_d;
    logic [BCW-1:0]     beat_q, beat_d;
    logic [GCW-1:0]     gap_q, gap_d;
    logic [L-1:0]       shift_q, shift_d, load_word;
    logic               want_next, last_beat;
    logic               trig_en_q, idle_q;
    logic [N_LANES-1:0] trig_d_q;
    logic [15:0]        frame_cnt_q;

    assign wr_word = {req.in_phi, req.in_band, req.in_bcid};

    trig_fifo #(
        .W     (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_slow (clk_slow),
        .reset    (reset),
        .push     (req.in_valid),
        .wr_data  (wr_word),
        .pop      (pop),
        .rd_data  (rd_word),
        .ready    (fifo_ready),
        .empty    (fifo_empty)
    );

    assign req.in_ready = fifo_ready;

    // Frame word left-aligned; padding LSBs stay zero
    always_comb begin
        load_word = '0;
        load_word[L-1 -: W] = rd_word;
    end

    assign last_beat = (state_q == SEND) && (beat_q == BCW'(BEATS - 1));

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        gap_d     = gap_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        want_next = 1'b0;
        unique case (state_q)
            IDLE: want_next = 1'b1;
            SEND: begin
                shift_d = shift_q << N_LANES;
                beat_d  = beat_q + 1'b1;
                if (last_beat) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end else begin
                        state_d   = IDLE;
                        want_next = 1'b1;
                    end
                end
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GCW'(GAP_CYCLES - 1)) begin
                    state_d   = IDLE;
                    want_next = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Loading in the same cycle the previous frame or gap ends keeps frames contiguous
        if (want_next && !fifo_empty) begin
            pop     = 1'b1;
            shift_d = load_word;
            beat_d  = '0;
            state_d = SEND;
        end
    end

    always_ff @(posedge clk_slow or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            gap_q       <= '0;
            shift_q     <= '0;
            trig_en_q   <= 1'b0;
            trig_d_q    <= '0;
            idle_q      <= 1'b1;
            frame_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            gap_q     <= gap_d;
            shift_q   <= shift_d;
            trig_en_q <= (state_q == SEND);
            trig_d_q  <= (state_q == SEND) ? shift_q[L-1 -: N_LANES] : '0;
            idle_q    <= (state_q == IDLE) && fifo_empty;
            if (last_beat && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign trig_en   = trig_en_q;
    assign trig_d    = trig_d_q;
    assign idle      = idle_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_strip_trigger_ser.sv
// Randomised self-checking bench: four builds (gap 1, gap 0, 1 lane, 25 lanes) against a frame model.
module tb_strip_trigger_ser;
    localparam int W = 25;

    logic clk_slow = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   exp_cnt_a = 0;

    always #5 clk_slow = ~clk_slow;

    strip_trigger_ser_if ifa ();
    strip_trigger_ser_if ifb ();
    strip_trigger_ser_if ifc ();
    strip_trigger_ser_if ifd ();

    logic        en_a, en_b, en_c, en_d;
    logic [3:0]  d_a, d_b;
    logic [0:0]  d_c;
    logic [24:0] d_d;
    logic        idle_a, idle_b, idle_c, idle_d;
    logic [15:0] cnt_a, cnt_b, cnt_c, cnt_d;

    strip_trigger_ser #(.GAP_CYCLES(1)) ua (
        .clk_slow(clk_slow), .reset(reset), .req(ifa),
        .trig_en(en_a), .trig_d(d_a), .idle(idle_a), .frame_cnt(cnt_a));
    strip_trigger_ser #(.GAP_CYCLES(0)) ub (
        .clk_slow(clk_slow), .reset(reset), .req(ifb),
        .trig_en(en_b), .trig_d(d_b), .idle(idle_b), .frame_cnt(cnt_b));
    strip_trigger_ser #(.N_LANES(1)) uc (
        .clk_slow(clk_slow), .reset(reset), .req(ifc),
        .trig_en(en_c), .trig_d(d_c), .idle(idle_c), .frame_cnt(cnt_c));
    strip_trigger_ser #(.N_LANES(25)) ud (
        .clk_slow(clk_slow), .reset(reset), .req(ifd),
        .trig_en(en_d), .trig_d(d_d), .idle(idle_d), .frame_cnt(cnt_d));

    // Per-cycle output logs: {trig_en, trig_d zero-extended}
    logic [25:0] log_a[$], log_b[$], log_c[$], log_d[$];
    always @(negedge clk_slow) begin
        if (!reset) begin
            log_a.push_back({en_a, 25'(d_a)});
            log_b.push_back({en_b, 25'(d_b)});
            log_c.push_back({en_c, 25'(d_c)});
            log_d.push_back({en_d, d_d});
        end
    end

    // Reference model: beat b of frame f on n lanes, from the padded frame word
    function automatic logic [24:0] beat_of(input logic [24:0] f, input int n, input int b);
        int          beats;
        int          l;
        logic [63:0] p;
        beats = (W + n - 1) / n;
        l     = beats * n;
        p     = 64'(f) << (l - W);
        p     = p >> (l - (b + 1) * n);
        return 25'(p & ((64'd1 << n) - 64'd1));
    endfunction

    logic [25:0] cur[$];
    int          runs[$];
    int          gaps[$];
    logic [24:0] seen[$];
    logic [24:0] exp_q[$];
    int          stray;

    // Splits a log into enable runs, low gaps between runs, and the beat data stream
    function automatic void scan();
        int run = 0;
        int low = 0;
        bit started = 0;
        runs.delete(); gaps.delete(); seen.delete(); stray = 0;
        foreach (cur[i]) begin
            if (cur[i][25]) begin
                if (run == 0 && started) gaps.push_back(low);
                run++;
                started = 1;
                seen.push_back(cur[i][24:0]);
            end else begin
                if (run != 0) begin
                    runs.push_back(run);
                    run = 0;
                    low = 0;
                end
                low++;
                if (cur[i][24:0] != '0) stray++;
            end
        end
        if (run != 0) runs.push_back(run);
    endfunction

    function automatic void add_expected(input logic [24:0] f, input int n);
        for (int b = 0; b < (W + n - 1) / n; b++) exp_q.push_back(beat_of(f, n, b));
    endfunction

    function automatic logic [24:0] rand_frame();
        return 25'($urandom);
    endfunction

    task automatic set_req(input logic [3:0] mask, input logic [24:0] f);
        ifa.in_valid = mask[0]; ifb.in_valid = mask[1];
        ifc.in_valid = mask[2]; ifd.in_valid = mask[3];
        ifa.in_phi = f[24:20]; ifa.in_band = f[19:12]; ifa.in_bcid = f[11:0];
        ifb.in_phi = f[24:20]; ifb.in_band = f[19:12]; ifb.in_bcid = f[11:0];
        ifc.in_phi = f[24:20]; ifc.in_band = f[19:12]; ifc.in_bcid = f[11:0];
        ifd.in_phi = f[24:20]; ifd.in_band = f[19:12]; ifd.in_bcid = f[11:0];
    endtask

    task automatic clear_logs();
        log_a.delete(); log_b.delete(); log_c.delete(); log_d.delete();
    endtask

    task automatic test_reset();
        set_req(4'b0000, '0);
        #2 reset = 1'b1;
        repeat (3) @(posedge clk_slow);
        @(negedge clk_slow);
        total++; if (en_a !== 1'b0) begin bad++; $display("FAIL reset_en got=%b want=0", en_a); end
        total++; if (d_a !== 4'h0) begin bad++; $display("FAIL reset_d got=%h want=0", d_a); end
        total++; if (idle_a !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", idle_a); end
        total++; if (cnt_a !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h want=0", cnt_a); end
        total++; if (ifa.in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ifa.in_ready); end
        reset = 1'b0;
        @(negedge clk_slow);
        total++; if (ifa.in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_release got=%b want=1", ifa.in_ready); end
        total++; if (idle_a !== 1'b1) begin bad++; $display("FAIL idle_after_release got=%b want=1", idle_a); end
    endtask

    task automatic test_single_frame();
        logic [3:0] want [7];
        logic       exp_en;
        logic [3:0] exp_d;
        want = '{4'hA, 4'hD, 4'h2, 4'h8, 4'h9, 4'h1, 4'h8};
        @(posedge clk_slow); #1 set_req(4'b0001, {5'h15, 8'hA5, 12'h123});
        @(posedge clk_slow); #1 set_req(4'b0000, '0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_slow);
            exp_en = (k >= 2 && k <= 8);
            exp_d  = 4'h0;
            if (exp_en) exp_d = want[k-2];
            total++; if (en_a !== exp_en) begin bad++; $display("FAIL single_en k=%0d got=%b want=%b", k, en_a, exp_en); end
            total++; if (d_a !== exp_d) begin bad++; $display("FAIL single_d k=%0d got=%h want=%h", k, d_a, exp_d); end
            if (k == 2) begin
                total++; if (idle_a !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b want=0", idle_a); end
            end
        end
        repeat (4) @(negedge clk_slow);
        exp_cnt_a = 1;
        total++; if (cnt_a !== 16'(exp_cnt_a)) begin bad++; $display("FAIL single_cnt got=%0d want=%0d", cnt_a, exp_cnt_a); end
        total++; if (idle_a !== 1'b1) begin bad++; $display("FAIL single_idle_end got=%b want=1", idle_a); end
    endtask

    task automatic test_lanes();
        logic [24:0] f;
        f = {5'h15, 8'hA5, 12'h123};
        clear_logs();
        @(posedge clk_slow); #1 set_req(4'b1100, f);
        @(posedge clk_slow); #1 set_req(4'b0000, '0);
        repeat (40) @(negedge clk_slow);
        cur = log_c; scan(); exp_q.delete(); add_expected(f, 1);
        total++; if (runs.size() != 1 || runs[0] != 25) begin
            bad++; $display("FAIL lanes1_runs got=%0d runs want=1 run of 25", runs.size()); end
        total++; if (seen != exp_q) begin bad++; $display("FAIL lanes1_beats got=%0d beats want=%0d matching", seen.size(), exp_q.size()); end
        total++; if (cnt_c !== 16'd1) begin bad++; $display("FAIL lanes1_cnt got=%0d want=1", cnt_c); end
        cur = log_d; scan();
        total++; if (runs.size() != 1 || runs[0] != 1) begin
            bad++; $display("FAIL lanes25_runs got=%0d runs want=1 run of 1", runs.size()); end
        total++; if (seen.size() != 1 || seen[0] !== f) begin
            bad++; $display("FAIL lanes25_data got=%0d beats want=1 beat of %h", seen.size(), f); end
        total++; if (cnt_d !== 16'd1) begin bad++; $display("FAIL lanes25_cnt got=%0d want=1", cnt_d); end
    endtask

    task automatic test_back_to_back();
        logic [24:0] f;
        clear_logs();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            f = rand_frame();
            add_expected(f, 4);
            @(posedge clk_slow); #1 set_req(4'b0011, f);
        end
        @(posedge clk_slow); #1 set_req(4'b0000, '0);
        repeat (50) @(negedge clk_slow);
        cur = log_b; scan();
        total++; if (runs.size() != 1 || runs[0] != 21) begin
            bad++; $display("FAIL b2b_nogap_runs got=%0d runs want=1 run of 21", runs.size()); end
        total++; if (seen != exp_q) begin bad++; $display("FAIL b2b_nogap_beats got=%0d beats want=%0d matching", seen.size(), exp_q.size()); end
        total++; if (cnt_b !== 16'd3) begin bad++; $display("FAIL b2b_nogap_cnt got=%0d want=3", cnt_b); end
        cur = log_a; scan();
        total++; if (runs.size() != 3 || runs[0] != 7 || runs[1] != 7 || runs[2] != 7) begin
            bad++; $display("FAIL b2b_gap_runs got=%0d runs want=3 runs of 7", runs.size()); end
        total++; if (gaps.size() != 2 || gaps[0] != 1 || gaps[1] != 1) begin
            bad++; $display("FAIL b2b_gap_gaps got=%0d gaps want=2 gaps of 1", gaps.size()); end
        total++; if (seen != exp_q) begin bad++; $display("FAIL b2b_gap_beats got=%0d beats want=%0d matching", seen.size(), exp_q.size()); end
        total++; if (stray != 0) begin bad++; $display("FAIL b2b_gap_stray got=%0d want=0", stray); end
        exp_cnt_a += 3;
        total++; if (cnt_a !== 16'(exp_cnt_a)) begin bad++; $display("FAIL b2b_gap_cnt got=%0d want=%0d", cnt_a, exp_cnt_a); end
    endtask

    task automatic test_backpressure();
        logic [24:0] f;
        int          n = 0;
        int          guard = 0;
        bit          blocked = 0;
        logic        r;
        clear_logs();
        exp_q.delete();
        @(posedge clk_slow); #1;
        f = rand_frame();
        set_req(4'b0001, f);
        while (n < 10 && guard < 400) begin
            @(negedge clk_slow);
            r = ifa.in_ready;
            if (!r) blocked = 1;
            @(posedge clk_slow); #1;
            guard++;
            if (r) begin
                add_expected(f, 4);
                n++;
                f = rand_frame();
                if (n < 10) set_req(4'b0001, f); else set_req(4'b0000, '0);
            end
        end
        set_req(4'b0000, '0);
        total++; if (n != 10) begin bad++; $display("FAIL bp_accepts got=%0d want=10", n); end
        total++; if (!blocked) begin bad++; $display("FAIL bp_ready_drop got=never want=low once full"); end
        repeat (40) @(negedge clk_slow);
        cur = log_a; scan();
        total++; if (runs.size() != 10) begin bad++; $display("FAIL bp_frames got=%0d want=10", runs.size()); end
        total++; if (seen != exp_q) begin bad++; $display("FAIL bp_order got=%0d beats want=%0d matching", seen.size(), exp_q.size()); end
        exp_cnt_a += 10;
        total++; if (cnt_a !== 16'(exp_cnt_a)) begin bad++; $display("FAIL bp_cnt got=%0d want=%0d", cnt_a, exp_cnt_a); end
    endtask

    task automatic test_reset_midframe();
        logic [24:0] f;
        int          beats = 0;
        int          guard = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_slow); #1 set_req(4'b0001, rand_frame());
        end
        @(posedge clk_slow); #1 set_req(4'b0000, '0);
        while (beats < 3 && guard < 50) begin
            @(negedge clk_slow);
            guard++;
            if (en_a) beats++;
        end
        total++; if (beats != 3) begin bad++; $display("FAIL midrst_reach_beat got=%0d want=3", beats); end
        #2 reset = 1'b1;
        #1;
        total++; if (en_a !== 1'b0) begin bad++; $display("FAIL midrst_en got=%b want=0", en_a); end
        total++; if (d_a !== 4'h0) begin bad++; $display("FAIL midrst_d got=%h want=0", d_a); end
        total++; if (idle_a !== 1'b1) begin bad++; $display("FAIL midrst_idle got=%b want=1", idle_a); end
        total++; if (cnt_a !== 16'h0) begin bad++; $display("FAIL midrst_cnt got=%0d want=0", cnt_a); end
        @(negedge clk_slow);
        reset = 1'b0;
        clear_logs();
        repeat (40) @(negedge clk_slow);
        cur = log_a; scan();
        total++; if (runs.size() != 0) begin bad++; $display("FAIL midrst_silent got=%0d runs want=0", runs.size()); end
        exp_q.delete();
        f = rand_frame();
        add_expected(f, 4);
        clear_logs();
        @(posedge clk_slow); #1 set_req(4'b0001, f);
        @(posedge clk_slow); #1 set_req(4'b0000, '0);
        repeat (15) @(negedge clk_slow);
        cur = log_a; scan();
        total++; if (seen != exp_q) begin bad++; $display("FAIL midrst_fresh got=%0d beats want=%0d matching", seen.size(), exp_q.size()); end
        exp_cnt_a = 1;
        total++; if (cnt_a !== 16'(exp_cnt_a)) begin bad++; $display("FAIL midrst_fresh_cnt got=%0d want=%0d", cnt_a, exp_cnt_a); end
    endtask

    task automatic test_saturation();
        @(negedge clk_slow);
        force ua.frame_cnt_q = 16'hFFFE;
        #1 release ua.frame_cnt_q;
        clear_logs();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_slow); #1 set_req(4'b0001, rand_frame());
        end
        @(posedge clk_slow); #1 set_req(4'b0000, '0);
        repeat (30) @(negedge clk_slow);
        cur = log_a; scan();
        total++; if (runs.size() != 2) begin bad++; $display("FAIL sat_frames got=%0d want=2", runs.size()); end
        total++; if (cnt_a !== 16'hFFFF) begin bad++; $display("FAIL sat_cnt got=%h want=ffff", cnt_a); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_lanes();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/strip_trigger_ser.md
# strip_trigger_ser

Parametrised strip trigger serialiser: queues trigger requests (phi ID, band ID, BCID) through a valid/ready interface in a small FIFO. Each request is emitted as a framed, MSB-first burst over N_LANES parallel data lanes plus an enable lane, one beat per clk_slow cycle, with a programmable idle gap between frames. It sits between trigger decision logic and the per-lane DDR/OSERDES output primitives, which remain outside this block.

## Interface
- PHI_W, 5, phi ID field width
- BAND_W, 8, band ID field width
- BCID_W, 12, BCID field width
- N_LANES, 4, data lanes (≥1)
- FIFO_DEPTH, 4, request queue depth (power of two, ≥2)
- GAP_CYCLES, 1, idle cycles forced after each frame (≥0)
- clk_slow  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  FIFO not full; reset 0, then 1 from first edge after release
- in_phi  in  PHI_W  phi ID
- in_band  in  BAND_W  band ID
- in_bcid  in  BCID_W  BCID
- trig_en  out  1  high on every frame beat; reset 0
- trig_d  out  N_LANES  beat data; reset 0
- idle  out  1  FSM IDLE and FIFO empty; reset 1
- frame_cnt  out  16  frames completed, saturating; reset 0

## Operation
- Frame word F = {phi, band, bcid}, W = PHI_W+BAND_W+BCID_W.
- BEATS = ceil(W/N_LANES), L = BEATS·N_LANES. F_pad = F followed by L−W zero LSBs.
- Beat b (0..BEATS−1): trig_d = F_pad[L−1−b·N_LANES -: N_LANES].
- Push when in_valid & in_ready. in_ready = !full. A push into a full FIFO is never accepted, even when a pop occurs in the same cycle.
- FSM states:
  - IDLE: if FIFO not empty, pop the head into the shift register and go to SEND.
  - SEND: emit one beat per cycle. After the last beat, go to GAP if GAP_CYCLES>0. Otherwise, if the FIFO is not empty, pop the next entry and stay in SEND (back-to-back frames); else go to IDLE.
  - GAP: count GAP_CYCLES cycles with trig_en=0 and trig_d=0, then behave as IDLE.
- Outside SEND: trig_en=0, trig_d=0.
- frame_cnt increments on the last beat of each frame and holds at 16'hFFFF.
- Input fields are captured at push; later input changes do not affect a queued or in-flight frame.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronous), the FIFO is emptied, the partial frame is discarded and never resumed.

## Timing
- All outputs are registered.
- Latency: push accepted at edge T into an empty FIFO with the FSM in IDLE gives the first beat valid after edge T+2. trig_en stays high for exactly BEATS consecutive cycles.
- Frame spacing: consecutive queued frames are separated by exactly GAP_CYCLES cycles with trig_en low. With GAP_CYCLES=0 they are separated by none.
- in_ready rises the cycle after the pop that frees a full FIFO.
- idle falls the cycle after a push into an empty queue. idle rises the cycle after the final beat, or after the gap completes when GAP_CYCLES>0.

## Structure
- Shared package strip_trig_pkg holds:
  - the default field widths;
  - the frame-width/beat-count constant functions;
  - the FSM state enum {IDLE, SEND, GAP}.
- Sub-module trig_fifo: synchronous FIFO, width W, depth FIFO_DEPTH, with full/empty flags and asynchronous reset.
- The top level contains the FSM, the beat counter, the gap counter, the shift register and frame_cnt.

## Test plan
- Single frame, defaults: phi=5'h15, band=8'hA5, bcid=12'h123 → after edge T+2, trig_d = A,D,2,8,9,1,8 over 7 cycles with trig_en=1 throughout; frame_cnt=1; idle back to 1.
- Back-to-back with GAP_CYCLES=0: push 3 frames on consecutive cycles → 21 contiguous trig_en cycles; frame_cnt=3.
- Back-to-back with GAP_CYCLES=1: push 3 frames on consecutive cycles → exactly 1 low trig_en cycle between frames.
- Backpressure: hold in_valid for 10 pushes with default depth → in_ready drops after the FIFO fills; no push is lost or duplicated, and the output order matches input order.
- Reset at beat 3 of a frame with 2 requests queued → trig_en and trig_d are 0 immediately, idle=1, frame_cnt=0; nothing is emitted after release until a new push.
- N_LANES=1 and N_LANES=25 builds: same frame as the single-frame test → 25 serial beats of F; and a single beat with trig_d=F, respectively.
- Saturation: force frame_cnt to 16'hFFFE, send 2 frames → frame_cnt holds at 16'hFFFF.
